// File: rtl/seg7_scan_display.sv
`timescale 1ns/1ps
// Multiplexed 7-segment driver: binary in over valid/ready, sequential double-dabble to BCD,
// scanned common-anode output. Optional hex bypass enabled by defining SEG7_HEX_MODE_EN.
module seg7_scan_display #(
    parameter int WIDTH    = 8,
    parameter int NDIGITS  = 4,
    parameter int SCAN_DIV = 512,
    parameter int BLANK_LZ = 1
) (
    input  logic               CLKIN,
    input  logic               RESET_N,
    input  logic [WIDTH-1:0]   DATA,
    input  logic [NDIGITS-1:0] DP,
    input  logic               DATA_VALID,
`ifdef SEG7_HEX_MODE_EN
    input  logic               HEX,
`endif
    output logic               DATA_READY,
    output logic [7:0]         SEG,
    output logic [NDIGITS-1:0] SEL
);

    // ceil(WIDTH*0.302 + 1) in integer arithmetic; never narrower than the display
    localparam int BCD_NIB = (WIDTH * 302 + 1999) / 1000;
    localparam int ACC_NIB = (BCD_NIB > NDIGITS) ? BCD_NIB : NDIGITS;
    localparam int ACC_W   = 4 * ACC_NIB;
    localparam int CNT_W   = $clog2(WIDTH);
    localparam int IDX_W   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int DIV_W   = $clog2(SCAN_DIV);

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     bin_q, bin_d;
    logic [ACC_W-1:0]     bcd_q, bcd_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NDIGITS-1:0]   dp_pend_q, dp_pend_d;
    logic [4*NDIGITS-1:0] disp_q, disp_d;
    logic [NDIGITS-1:0]   dp_q, dp_d;
    logic                 ovf_q, ovf_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [7:0]           seg_q, seg_d;
    logic [NDIGITS-1:0]   sel_q, sel_d;

    logic [ACC_W-1:0]     bcd_adj;
    logic [ACC_W-1:0]     bcd_shift;
    logic [NDIGITS-1:0]   blank;
    logic [3:0]           cur_nib;
    logic                 cur_dp;
    logic                 cur_blank;
`ifdef SEG7_HEX_MODE_EN
    logic [ACC_W-1:0]     hex_ext;
`endif

    function automatic logic nib_ovf(input logic [ACC_W-1:0] v);
        logic r;
        r = 1'b0;
        for (int n = NDIGITS; n < ACC_NIB; n++) begin
            if (v[4*n +: 4] != 4'd0) r = 1'b1;
        end
        return r;
    endfunction

    // Segments {g,f,e,d,c,b,a}, active low
    function automatic logic [6:0] enc7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0: s = 7'h40;
            4'd1: s = 7'h79;
            4'd2: s = 7'h24;
            4'd3: s = 7'h30;
            4'd4: s = 7'h19;
            4'd5: s = 7'h12;
            4'd6: s = 7'h02;
            4'd7: s = 7'h78;
            4'd8: s = 7'h00;
            4'd9: s = 7'h10;
`ifdef SEG7_HEX_MODE_EN
            4'd10: s = 7'h08;
            4'd11: s = 7'h03;
            4'd12: s = 7'h46;
            4'd13: s = 7'h21;
            4'd14: s = 7'h06;
            4'd15: s = 7'h0E;
`endif
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < ACC_NIB; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                        bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
        end
    endgenerate

    assign bcd_shift  = ACC_W'({bcd_adj, bin_q[WIDTH-1]});
    assign DATA_READY = (state_q == S_IDLE);

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        dp_pend_d = dp_pend_q;
        disp_d    = disp_q;
        dp_d      = dp_q;
        ovf_d     = ovf_q;
`ifdef SEG7_HEX_MODE_EN
        hex_ext   = '0;
        hex_ext[WIDTH-1:0] = DATA;
`endif
        case (state_q)
            S_IDLE: begin
                if (DATA_VALID) begin
`ifdef SEG7_HEX_MODE_EN
                    if (HEX) begin
                        disp_d = hex_ext[4*NDIGITS-1:0];
                        dp_d   = DP;
                        ovf_d  = nib_ovf(hex_ext);
                    end else
`endif
                    begin
                        state_d   = S_CONV;
                        bin_d     = DATA;
                        bcd_d     = '0;
                        cnt_d     = CNT_W'(WIDTH - 1);
                        dp_pend_d = DP;
                    end
                end
            end
            S_CONV: begin
                bin_d = {bin_q[WIDTH-2:0], 1'b0};
                bcd_d = bcd_shift;
                // The last shift goes straight into the display so READY returns with it
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    disp_d  = bcd_shift[4*NDIGITS-1:0];
                    dp_d    = dp_pend_q;
                    ovf_d   = nib_ovf(bcd_shift);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        logic run;
        run   = 1'b1;
        blank = '0;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            run = run && (disp_q[4*i +: 4] == 4'd0);
            if (BLANK_LZ != 0 && i != 0) blank[i] = run;
        end
    end

    always_comb begin
        div_d     = (div_q == DIV_W'(SCAN_DIV - 1)) ? '0 : div_q + 1'b1;
        idx_d     = idx_q;
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            idx_d = (idx_q == IDX_W'(NDIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        cur_nib   = 4'd0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        sel_d     = '1;
        for (int i = 0; i < NDIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib   = disp_q[4*i +: 4];
                cur_dp    = dp_q[i];
                cur_blank = blank[i];
                sel_d[i]  = 1'b0;
            end
        end
        if (ovf_q)          seg_d = {~cur_dp, 7'h3F};
        else if (cur_blank) seg_d = {~cur_dp, 7'h7F};
        else                seg_d = {~cur_dp, enc7(cur_nib)};
    end

    always_ff @(posedge CLKIN or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= S_IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            dp_pend_q <= '0;
            disp_q    <= '0;
            dp_q      <= '0;
            ovf_q     <= 1'b0;
            div_q     <= '0;
            idx_q     <= '0;
            seg_q     <= 8'hFF;
            sel_q     <= '1;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            dp_pend_q <= dp_pend_d;
            disp_q    <= disp_d;
            dp_q      <= dp_d;
            ovf_q     <= ovf_d;
            div_q     <= div_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            sel_q     <= sel_d;
        end
    end

    assign SEG = seg_q;
    assign SEL = sel_q;

endmodule
